// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: state encoding and opcode constants shared by the pipeline control blocks
package pipeline_stall_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, BR_HOLD = 1'b1} state_e;
  localparam logic [6:0] OP_B = 7'b1100011;
endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use/branch hazard stall and redirect flush control with perf counters
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_stall,
  input  logic [1:0]       br_stall,
  input  logic             redirect,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  state_e state_q, state_d;
  logic   stall;
  // Reset and the hold cycle both force a stall regardless of inputs.
  always_comb begin
    stall       = !rst_n || state_q == BR_HOLD || br_stall[1] || br_stall[0] || load_stall;
    state_d     = (state_q == RUN && br_stall[1]) ? BR_HOLD : RUN;
    pc_write    = !stall;
    ifid_write  = !stall;
    idex_bubble = stall;
    ifid_flush  = !stall && redirect;
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(idex_bubble), .clr(cnt_clear), .cnt(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(ifid_flush), .clr(cnt_clear), .cnt(flush_count)
  );
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush performance counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port load_stall  input  1  load-use hazard flag from the hazard detector.
REQ-005 SHALL have port br_stall  input  2  bit0: branch operand produced in EX; bit1: branch operand produced by a load.
REQ-006 SHALL have port redirect  input  1  branch resolved in ID with PC change (taken or mispredict).
REQ-007 SHALL have port cnt_clear  input  1  synchronous clear of both performance counters.
REQ-008 SHALL have port pc_write  output  1  PC register update enable.
REQ-009 SHALL have port ifid_write  output  1  IF/ID register update enable.
REQ-010 SHALL have port idex_bubble  output  1  insert NOP into ID/EX (IsStall).
REQ-011 SHALL have port ifid_flush  output  1  squash the instruction in IF/ID.
REQ-012 SHALL have port stall_cycles  output  CNT_W  saturating count of stalled cycles.
REQ-013 SHALL have port flush_count  output  CNT_W  saturating count of flushes.

Function
REQ-014 SHALL implement FSM states RUN and BR_HOLD; BR_HOLD lasts exactly one cycle.
REQ-015 In RUN, with br_stall[1]=1, the block SHALL stall in the same cycle (pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0) and go to BR_HOLD.
REQ-016 In BR_HOLD, the block SHALL stall unconditionally, ignore all inputs, and return to RUN.
REQ-017 In RUN, with br_stall[1]=0 and (load_stall or br_stall[0])=1, the block SHALL stall in the same cycle and remain in RUN.
REQ-018 In RUN, with no stall condition and redirect=1, the block SHALL drive ifid_flush=1, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-019 In RUN, with no stall condition and redirect=0, the block SHALL drive pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
REQ-020 Priority SHALL be br_stall[1] > (load_stall | br_stall[0]) > redirect; redirect coincident with any stall SHALL be ignored.
REQ-021 Control outputs SHALL be combinational from state and inputs (zero latency); the hazard detector re-evaluates on the following cycle.
REQ-022 stall_cycles SHALL increment by 1 each cycle idex_bubble=1 and saturate at 2^CNT_W-1.
REQ-023 flush_count SHALL increment by 1 each cycle ifid_flush=1 and saturate at 2^CNT_W-1.
REQ-024 cnt_clear=1 SHALL zero both counters next edge and SHALL take precedence over increment in the same cycle.

Reset
REQ-025 With rst_n=0 at a rising edge, state SHALL become RUN and both counters 0, including when in BR_HOLD.
REQ-026 While rst_n=0, outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, and the counters SHALL not increment.
REQ-027 The first cycle after rst_n rises SHALL behave as RUN with no carried-over hold.

Structure
REQ-028 The state encoding (RUN=1'b0, BR_HOLD=1'b1) and opcode constant OP_B=7'b1100011 SHALL live in a shared pipeline package.
REQ-029 A single sub-module sat_counter (parameter width; inputs inc, clr) SHALL be instantiated twice for the performance counters.
REQ-030 The block SHALL contain no other sub-modules and no latches.

Verification
REQ-031 load_stall=1 for one cycle in RUN -> idex_bubble=1, pc_write=0 that cycle only; stall_cycles 0->1.
REQ-032 br_stall=2'b10 for one cycle -> two consecutive stall cycles (RUN then BR_HOLD), then RUN; stall_cycles=2.
REQ-033 redirect=1 together with load_stall=1 -> stall, ifid_flush=0, flush_count stays 0; next cycle redirect=1 alone -> ifid_flush=1, flush_count=1.
REQ-034 CNT_W=4, load_stall held 20 cycles -> stall_cycles saturates at 15; cnt_clear=1 with load_stall=1 -> 0.
REQ-035 rst_n=0 asserted during BR_HOLD -> next cycle state RUN, counters 0; after release with idle inputs, pc_write=1.
REQ-036 br_stall=2'b11 with redirect=1 -> treated as br_stall[1]: 2 stall cycles, no flush.
